// File: rtl/pacman_pkg.sv
// ============================================================================
// Module      : pacman_pkg
// Description : Shared Pac-Man types and constants (used by mover, ghosts, maze).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pacman_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    localparam logic [1:0] TILE_WALL = 2'b11;

    localparam int TILE_PX    = 8;
    localparam int Y_TILE_OFS = 3;
    localparam int CENTRE_OFS = 3;

    typedef logic [2:0] mover_state_t;
    localparam mover_state_t MV_IDLE    = 3'd0;
    localparam mover_state_t MV_MOVING  = 3'd1;
    localparam mover_state_t MV_STOPPED = 3'd2;
    localparam mover_state_t MV_DYING   = 3'd3;
    localparam mover_state_t MV_DEAD    = 3'd4;

    // Relative rotation: +1 is a left turn, +3 a right turn, +2 a reversal.
    function automatic logic [1:0] rotate_dir(input logic [1:0] d, input logic [1:0] delta);
        rotate_dir = d + delta;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pacman_input_edge.sv
// ============================================================================
// Module      : pacman_input_edge
// Description : Registered rising-edge detect; a pulse appears one frame after
//               the edge is sampled. rst is asynchronous, active-low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pacman_input_edge #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_level,
    output logic [WIDTH-1:0] o_rise
);

    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_rise;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev <= '0;
            r_rise <= '0;
        end else begin
            r_prev <= i_level;
            r_rise <= i_level & ~r_prev;
        end
    end

    assign o_rise = r_rise;

endmodule

`default_nettype wire

// File: rtl/pacman_mover.sv
// ============================================================================
// Module      : pacman_mover
// Description : Pac-Man movement controller: buffered turns, wall-checked pixel
//               stepping, tunnel wrap and walk/death animation. One frame per clk.
//               Optional: PACMAN_PELLET_STALL_EN (eating a pellet pauses a step).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pacman_mover
    import pacman_pkg::*;
#(
    parameter logic [6:0] START_XTILE  = 7'd14,
    parameter logic [6:0] START_YTILE  = 7'd23,
    parameter logic [9:0] MAZE_W_PX    = 10'd224,
    parameter logic [7:0] SPEED        = 8'd200,
    parameter logic [2:0] ANIM_DIV     = 3'd4,
    parameter logic [7:0] DEATH_FRAMES = 8'd120
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            left,
    input  logic            right,
    input  logic            uturn,
    input  logic            caught,
    input  logic            pellet_eaten,
    input  logic [3:0][1:0] tile_info,
    output logic [9:0]      xloc,
    output logic [9:0]      yloc,
    output logic [1:0]      dir,
    output logic [1:0]      anim,
    output logic            alive,
    output logic [6:0]      xtile,
    output logic [6:0]      ytile
);

    localparam logic [9:0] c_start_x     = 10'(START_XTILE) * 10'(TILE_PX) + 10'(CENTRE_OFS);
    localparam logic [9:0] c_start_y     = (10'(START_YTILE) + 10'(Y_TILE_OFS)) * 10'(TILE_PX)
                                           + 10'(CENTRE_OFS);
    localparam logic [7:0] c_death_phase = DEATH_FRAMES >> 2;

    logic [3:0] w_rise;
    logic       w_start_e, w_left_e, w_right_e, w_uturn_e;

    pacman_input_edge #(.WIDTH(4)) u_edge (
        .clk     (clk),
        .rst     (rst),
        .i_level ({start, left, right, uturn}),
        .o_rise  (w_rise)
    );

    assign {w_start_e, w_left_e, w_right_e, w_uturn_e} = w_rise;

    logic         w_stall;
`ifdef PACMAN_PELLET_STALL_EN
    assign w_stall = pellet_eaten;
`else
    logic w_unused_pellet;
    assign w_unused_pellet = pellet_eaten;
    assign w_stall         = 1'b0;
`endif

    mover_state_t r_state, w_nxt_state;
    logic [9:0]   r_xloc, w_nxt_xloc;
    logic [9:0]   r_yloc, w_nxt_yloc;
    logic [1:0]   r_dir, w_nxt_dir;
    logic [1:0]   r_anim, w_nxt_anim;
    logic         r_alive, w_nxt_alive;
    logic [7:0]   r_acc, w_nxt_acc;
    logic         r_pend_valid, w_nxt_pend_valid;
    logic         r_pend_left, w_nxt_pend_left;
    logic [2:0]   r_adiv, w_nxt_adiv;
    logic [7:0]   r_dcnt, w_nxt_dcnt;
    logic [7:0]   r_dphase, w_nxt_dphase;

    logic         w_centre;
    logic         w_pend_valid, w_pend_left;
    logic [1:0]   w_turn_dir, w_uturn_dir, w_move_dir;
    logic         w_turn_ok;
    logic         w_carry;
    logic [7:0]   w_acc_sum;

    function automatic logic [9:0] step_x(input logic [9:0] x, input logic [1:0] d);
        step_x = x;
        if (d == DIR_LEFT)
            step_x = (x == 10'd0) ? MAZE_W_PX - 10'd1 : x - 10'd1;
        else if (d == DIR_RIGHT)
            step_x = (x == MAZE_W_PX - 10'd1) ? 10'd0 : x + 10'd1;
    endfunction

    function automatic logic [9:0] step_y(input logic [9:0] y, input logic [1:0] d);
        step_y = y;
        if (d == DIR_UP)
            step_y = y - 10'd1;
        else if (d == DIR_DOWN)
            step_y = y + 10'd1;
    endfunction

    assign w_centre     = (r_xloc[2:0] == 3'(CENTRE_OFS)) && (r_yloc[2:0] == 3'(CENTRE_OFS));
    // A fresh request this frame overrides the stored one; right wins a tie.
    assign w_pend_valid = w_left_e | w_right_e | r_pend_valid;
    assign w_pend_left  = w_right_e ? 1'b0 : (w_left_e ? 1'b1 : r_pend_left);
    assign w_turn_dir   = rotate_dir(r_dir, w_pend_left ? 2'd1 : 2'd3);
    assign w_uturn_dir  = rotate_dir(r_dir, 2'd2);
    assign w_turn_ok    = w_pend_valid && (tile_info[w_turn_dir] != TILE_WALL);
    assign {w_carry, w_acc_sum} = {1'b0, r_acc} + {1'b0, SPEED};

    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_xloc       = r_xloc;
        w_nxt_yloc       = r_yloc;
        w_nxt_dir        = r_dir;
        w_nxt_anim       = r_anim;
        w_nxt_alive      = r_alive;
        w_nxt_acc        = r_acc;
        w_nxt_pend_valid = r_pend_valid;
        w_nxt_pend_left  = r_pend_left;
        w_nxt_adiv       = r_adiv;
        w_nxt_dcnt       = r_dcnt;
        w_nxt_dphase     = r_dphase;
        w_move_dir       = r_dir;

        case (r_state)
            MV_IDLE: begin
                if (w_start_e)
                    w_nxt_state = MV_MOVING;
            end

            MV_MOVING, MV_STOPPED: begin
                if (caught) begin
                    w_nxt_state      = MV_DYING;
                    w_nxt_alive      = 1'b0;
                    w_nxt_anim       = 2'd0;
                    w_nxt_dcnt       = 8'd0;
                    w_nxt_dphase     = 8'd0;
                    w_nxt_adiv       = 3'd0;
                    w_nxt_pend_valid = 1'b0;
                end else if (r_state == MV_STOPPED) begin
                    if (w_uturn_e) begin
                        w_nxt_dir        = w_uturn_dir;
                        w_nxt_pend_valid = 1'b0;
                        w_nxt_state      = MV_MOVING;
                    end else if (w_turn_ok) begin
                        w_nxt_dir        = w_turn_dir;
                        w_nxt_pend_valid = 1'b0;
                        w_nxt_state      = MV_MOVING;
                    end else begin
                        w_nxt_pend_valid = w_pend_valid;
                        w_nxt_pend_left  = w_pend_left;
                    end
                end else begin
                    if (r_adiv == ANIM_DIV - 3'd1) begin
                        w_nxt_adiv = 3'd0;
                        w_nxt_anim = r_anim + 2'd1;
                    end else begin
                        w_nxt_adiv = r_adiv + 3'd1;
                    end

                    w_nxt_pend_valid = w_pend_valid;
                    w_nxt_pend_left  = w_pend_left;
                    if (w_uturn_e) begin
                        w_move_dir       = w_uturn_dir;
                        w_nxt_pend_valid = 1'b0;
                    end else if (w_centre && w_turn_ok) begin
                        w_move_dir       = w_turn_dir;
                        w_nxt_pend_valid = 1'b0;
                    end
                    w_nxt_dir = w_move_dir;

                    if (w_centre && (tile_info[w_move_dir] == TILE_WALL)) begin
                        w_nxt_state = MV_STOPPED;
                    end else if (!w_stall) begin
                        w_nxt_acc = w_acc_sum;
                        if (w_carry) begin
                            w_nxt_xloc = step_x(r_xloc, w_move_dir);
                            w_nxt_yloc = step_y(r_yloc, w_move_dir);
                        end
                    end
                end
            end

            MV_DYING: begin
                if (r_dcnt == DEATH_FRAMES - 8'd1) begin
                    w_nxt_state = MV_DEAD;
                end else begin
                    w_nxt_dcnt = r_dcnt + 8'd1;
                    if (r_dphase == c_death_phase - 8'd1) begin
                        w_nxt_dphase = 8'd0;
                        w_nxt_anim   = r_anim + 2'd1;
                    end else begin
                        w_nxt_dphase = r_dphase + 8'd1;
                    end
                end
            end

            MV_DEAD: begin
                if (w_start_e) begin
                    w_nxt_state      = MV_MOVING;
                    w_nxt_xloc       = c_start_x;
                    w_nxt_yloc       = c_start_y;
                    w_nxt_dir        = DIR_LEFT;
                    w_nxt_anim       = 2'd0;
                    w_nxt_alive      = 1'b1;
                    w_nxt_acc        = 8'd0;
                    w_nxt_pend_valid = 1'b0;
                    w_nxt_adiv       = 3'd0;
                end
            end

            default: w_nxt_state = MV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= MV_IDLE;
            r_xloc       <= c_start_x;
            r_yloc       <= c_start_y;
            r_dir        <= DIR_LEFT;
            r_anim       <= 2'd0;
            r_alive      <= 1'b1;
            r_acc        <= 8'd0;
            r_pend_valid <= 1'b0;
            r_pend_left  <= 1'b0;
            r_adiv       <= 3'd0;
            r_dcnt       <= 8'd0;
            r_dphase     <= 8'd0;
        end else begin
            r_state      <= w_nxt_state;
            r_xloc       <= w_nxt_xloc;
            r_yloc       <= w_nxt_yloc;
            r_dir        <= w_nxt_dir;
            r_anim       <= w_nxt_anim;
            r_alive      <= w_nxt_alive;
            r_acc        <= w_nxt_acc;
            r_pend_valid <= w_nxt_pend_valid;
            r_pend_left  <= w_nxt_pend_left;
            r_adiv       <= w_nxt_adiv;
            r_dcnt       <= w_nxt_dcnt;
            r_dphase     <= w_nxt_dphase;
        end
    end

    assign xloc  = r_xloc;
    assign yloc  = r_yloc;
    assign dir   = r_dir;
    assign anim  = r_anim;
    assign alive = r_alive;
    assign xtile = r_xloc[9:3];
    assign ytile = r_yloc[9:3] - 7'(Y_TILE_OFS);

endmodule

`default_nettype wire
